// File: rtl/axi_w_arbiter.sv
// rtl/axi_w_arbiter.sv - two-master AXI write-channel arbiter feeding AW and W FIFOs
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m0_*/m1_* awvalid/awpkt  master address requests (AWLEN in awpkt[3:0])
//   m0_*/m1_* awready        address accepted this cycle
//   m0_*/m1_* wvalid/wpkt    master write beats {WDATA[36:5], WSTRB[4:1], WLAST[0]}
//   m0_*/m1_* wready         write beat accepted this cycle
//   aw_push/aw_data/aw_full  downstream address FIFO
//   w_push/w_data/w_full     downstream write-data FIFO
//   grant                    one-hot current owner, 2'b00 when idle
//   len_err                  one-cycle pulse after a beat disagreeing with AWLEN
module axi_w_arbiter #(
  parameter int AWP_W = 45
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_awvalid,
  input  logic [AWP_W-1:0] m0_awpkt,
  output logic             m0_awready,
  input  logic             m0_wvalid,
  input  logic [36:0]      m0_wpkt,
  output logic             m0_wready,
  input  logic             m1_awvalid,
  input  logic [AWP_W-1:0] m1_awpkt,
  output logic             m1_awready,
  input  logic             m1_wvalid,
  input  logic [36:0]      m1_wpkt,
  output logic             m1_wready,
  output logic             aw_push,
  output logic [AWP_W-1:0] aw_data,
  input  logic             aw_full,
  output logic             w_push,
  output logic [36:0]      w_data,
  input  logic             w_full,
  output logic [1:0]       grant,
  output logic             len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic [1:0] grant_q;
  logic       last_m1;   // 1 when M1 owned the most recent burst
  logic [3:0] beat_cnt;  // beats still expected before WLAST
  logic       len_err_q;

  logic             sel_m1;
  logic             in_addr;
  logic             in_data;
  logic             g_awvalid;
  logic [AWP_W-1:0] g_awpkt;
  logic             g_wvalid;
  logic [36:0]      g_wpkt;
  logic             w_last;

  assign grant   = grant_q;
  assign len_err = len_err_q;

  assign sel_m1    = grant_q[1];
  assign in_addr   = (state == ADDR);
  assign in_data   = (state == DATA);
  assign g_awvalid = sel_m1 ? m1_awvalid : m0_awvalid;
  assign g_awpkt   = sel_m1 ? m1_awpkt : m0_awpkt;
  assign g_wvalid  = sel_m1 ? m1_wvalid : m0_wvalid;
  assign g_wpkt    = sel_m1 ? m1_wpkt : m0_wpkt;
  assign w_last    = g_wpkt[0];

  // Readies depend only on state, owner and FIFO full, never on the master's valid.
  assign m0_awready = in_addr & grant_q[0] & ~aw_full;
  assign m1_awready = in_addr & grant_q[1] & ~aw_full;
  assign m0_wready  = in_data & grant_q[0] & ~w_full;
  assign m1_wready  = in_data & grant_q[1] & ~w_full;

  assign aw_push = in_addr & g_awvalid & ~aw_full;
  assign w_push  = in_data & g_wvalid & ~w_full;
  assign aw_data = aw_push ? g_awpkt : '0;
  assign w_data  = w_push ? g_wpkt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= 2'b00;
      last_m1   <= 1'b1;
      beat_cnt  <= 4'd0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_awvalid | m1_awvalid) begin
            // On a tie the master that did not own the last burst wins.
            if (m0_awvalid & m1_awvalid)
              grant_q <= last_m1 ? 2'b01 : 2'b10;
            else
              grant_q <= m0_awvalid ? 2'b01 : 2'b10;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_push) begin
            beat_cnt <= g_awpkt[3:0];
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_push) begin
            len_err_q <= w_last ? (beat_cnt != 4'd0) : (beat_cnt == 4'd0);
            if (w_last) begin
              // Only WLAST ends a burst; a short or long burst is flagged, not cut.
              state   <= IDLE;
              last_m1 <= grant_q[1];
              grant_q <= 2'b00;
            end else if (beat_cnt != 4'd0) begin
              beat_cnt <= beat_cnt - 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule
